perceptron_layer_ctrl: RTL and testbench

Sequencer that time-shares one combinational `perceptron` datapath across a layer of `NEURONS` neurons. Holds each neuron's 8 weights and bias in an internal register bank, loaded through a config port. Accepts one 8-bit input vector over a valid/ready handshake and steps through the neurons, driving the shared perceptron's operand ports. Returns one registered result per neuron over a valid/ready output stream, tagged with neuron index and last flag.

---
 rtl/perceptron_layer_ctrl.sv | 144 ++++++++++++++
 tb/tb_perceptron_layer_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_layer_ctrl.sv
// Time-shares one perceptron datapath across a layer of NEURONS neurons.
// Optional ReLU on each result when PERC_RELU_EN is defined.
module perceptron_layer_ctrl #(
   parameter int NEURONS = 4,
   parameter int IDX_W   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_neuron,
   input  logic [3:0]       cfg_sel,
   input  logic [7:0]       cfg_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   output logic [7:0]       p_in,
   output logic [7:0]       p_w0,
   output logic [7:0]       p_w1,
   output logic [7:0]       p_w2,
   output logic [7:0]       p_w3,
   output logic [7:0]       p_w4,
   output logic [7:0]       p_w5,
   output logic [7:0]       p_w6,
   output logic [7:0]       p_w7,
   output logic [7:0]       p_bias,
   input  logic [7:0]       p_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_data,
   output logic [IDX_W-1:0] res_idx,
   output logic             res_last,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NEURONS - 1);

   state_t           state, state_nx;
   logic [7:0]       x_reg;
   logic [IDX_W-1:0] idx;
   logic [7:0]       wbank [NEURONS][8];
   logic [7:0]       bbank [NEURONS];
   logic             accept, eval, fire, cfg_ok;
   logic [7:0]       act;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      eval     = 1'b0;
      fire     = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               accept   = 1'b1;
               state_nx = EVAL;
            end
         end
         EVAL: begin
            eval     = 1'b1;
            state_nx = HOLD;
         end
         HOLD: begin
            if (res_valid && res_ready) begin
               fire     = 1'b1;
               state_nx = res_last ? IDLE : EVAL;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign in_ready  = !busy;
   assign cfg_ready = !busy;
   assign p_in      = busy ? x_reg : 8'h00;

   assign p_w0   = wbank[idx][0];
   assign p_w1   = wbank[idx][1];
   assign p_w2   = wbank[idx][2];
   assign p_w3   = wbank[idx][3];
   assign p_w4   = wbank[idx][4];
   assign p_w5   = wbank[idx][5];
   assign p_w6   = wbank[idx][6];
   assign p_w7   = wbank[idx][7];
   assign p_bias = bbank[idx];

`ifdef PERC_RELU_EN
   // p_out read as two's complement; negatives clamp to zero
   assign act = p_out[7] ? 8'h00 : p_out;
`else
   assign act = p_out;
`endif

   assign cfg_ok = cfg_we && cfg_ready
                && (32'(cfg_neuron) < NEURONS)
                && (cfg_sel <= 4'd8);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         x_reg     <= 8'h00;
         idx       <= '0;
         res_valid <= 1'b0;
         res_data  <= 8'h00;
         res_idx   <= '0;
         res_last  <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            x_reg <= in_data;
            idx   <= '0;
         end
         if (eval) begin
            res_data  <= act;
            res_idx   <= idx;
            res_last  <= (idx == LAST);
            res_valid <= 1'b1;
         end
         if (fire) begin
            res_valid <= 1'b0;
            if (!res_last)
               idx <= idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < NEURONS; n++) begin
            bbank[n] <= 8'h00;
            for (int i = 0; i < 8; i++)
               wbank[n][i] <= 8'h00;
         end
      end else if (cfg_ok) begin
         if (cfg_sel == 4'd8)
            bbank[cfg_neuron] <= cfg_data;
         else
            wbank[cfg_neuron][cfg_sel[2:0]] <= cfg_data;
      end
   end

endmodule

// File: tb/tb_perceptron_layer_ctrl.sv
// Scoreboard bench for perceptron_layer_ctrl with a behavioural perceptron.
module tb_perceptron_layer_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic       cfg_ready;
   logic [1:0] cfg_neuron;
   logic [3:0] cfg_sel;
   logic [7:0] cfg_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] p_in, p_w0, p_w1, p_w2, p_w3;
   logic [7:0] p_w4, p_w5, p_w6, p_w7, p_bias;
   logic [7:0] p_out;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [1:0] res_idx;
   logic       res_last;
   logic       busy;

   int nvec = 0;
   int nerr = 0;
   logic [10:0] sbq[$];
   logic [10:0] exp_e;

`ifdef PERC_RELU_EN
   localparam logic [7:0] N2 = 8'h00;
`else
   localparam logic [7:0] N2 = 8'h90;
`endif

   always #5 clk = ~clk;

   perceptron_layer_ctrl #(.NEURONS(4), .IDX_W(2)) dut (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we), .cfg_ready(cfg_ready),
      .cfg_neuron(cfg_neuron), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data),
      .p_in(p_in),
      .p_w0(p_w0), .p_w1(p_w1), .p_w2(p_w2), .p_w3(p_w3),
      .p_w4(p_w4), .p_w5(p_w5), .p_w6(p_w6), .p_w7(p_w7),
      .p_bias(p_bias), .p_out(p_out),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_idx(res_idx),
      .res_last(res_last), .busy(busy)
   );

   // behavioural perceptron: gated weight sum plus bias, mod 256
   always_comb begin
      logic [7:0] w [8];
      logic [7:0] s;
      w = '{p_w0, p_w1, p_w2, p_w3, p_w4, p_w5, p_w6, p_w7};
      s = p_bias;
      for (int i = 0; i < 8; i++)
         if (p_in[i]) s = s + w[i];
      p_out = s;
   end

   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         nvec++;
         if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL result: unexpected idx %0d data %02h",
                     res_idx, res_data);
         end else begin
            exp_e = sbq.pop_front();
            if ({res_data, res_idx, res_last} !== exp_e) begin
               nerr++;
               $display("FAIL result: got d=%02h i=%0d l=%0b want d=%02h i=%0d l=%0b",
                        res_data, res_idx, res_last,
                        exp_e[10:3], exp_e[2:1], exp_e[0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, a, e);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic [1:0] i,
                       input logic l);
      sbq.push_back({d, i, l});
   endtask

   task automatic cfgw(input logic [1:0] n, input logic [3:0] s,
                       input logic [7:0] d);
      cfg_we = 1'b1;
      cfg_neuron = n;
      cfg_sel = s;
      cfg_data = d;
      @(posedge clk);
      #1 cfg_we = 1'b0;
   endtask

   task automatic send(input logic [7:0] x);
      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      in_data = x;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("eval_valid_low", res_valid, 0);
      chk("in_ready_busy", in_ready, 0);
      @(negedge clk);
      chk("valid_t2", res_valid, 1);
      chk("idx_t2", res_idx, 0);
   endtask

   task automatic wait_valid();
      int k = 0;
      @(negedge clk);
      while (!res_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("wait_valid_bound", res_valid, 1);
   endtask

   task automatic wait_last();
      int k = 0;
      @(negedge clk);
      while (!(res_valid && res_last && res_ready) && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("wait_last_bound", res_valid && res_last, 1);
      @(negedge clk);
      chk("in_ready_after_last", in_ready, 1);
      chk("valid_after_last", res_valid, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      cfg_we = 1'b0;
      cfg_neuron = '0;
      cfg_sel = '0;
      cfg_data = '0;
      in_valid = 1'b0;
      in_data = '0;
      res_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_valid", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_idx", res_idx, 0);
      chk("rst_last", res_last, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cfg_ready", cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_p_in", p_in, 0);
      chk("rst_p_bias", p_bias, 0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++) cfgw(2'd0, 4'(i), 8'(i + 1));
      cfgw(2'd0, 4'd8, 8'h05);
      chk("cfg_vis_bias", p_bias, 8'h05);
      chk("cfg_vis_w7", p_w7, 8'h08);
      for (int i = 0; i < 8; i++) cfgw(2'd1, 4'(i), 8'h40);
      cfgw(2'd1, 4'd8, 8'h00);
      cfgw(2'd2, 4'd8, 8'h90);
      for (int i = 0; i < 8; i++) cfgw(2'd3, 4'(i), 8'h08);
      cfgw(2'd3, 4'd8, 8'h01);

      // run 1: free-flowing consumer
      res_ready = 1'b1;
      push(8'h0F, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      push(N2,    2'd2, 1'b0);
      push(8'h21, 2'd3, 1'b1);
      send(8'h0F);
      @(posedge clk);
      #1;
      wait_last();

      // run 2: back-pressure on neuron1
      res_ready = 1'b0;
      push(8'h29, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      push(N2,    2'd2, 1'b0);
      push(8'h41, 2'd3, 1'b1);
      send(8'hFF);
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      wait_valid();
      chk("hold_idx_first", res_idx, 1);
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", res_valid, 1);
         chk("hold_data", res_data, 8'h00);
         chk("hold_idx", res_idx, 1);
         chk("hold_pw0", p_w0, 8'h40);
         chk("hold_pin", p_in, 8'hFF);
      end
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_last();

      // dropped writes while idle, then a legal one on the current idx
      cfgw(2'd0, 4'd9, 8'hAA);
      cfgw(2'd1, 4'd15, 8'hAA);
      cfgw(2'd3, 4'd8, 8'h03);
      chk("cfg_vis_idx3", p_bias, 8'h03);
      chk("cfg_idx3_w0", p_w0, 8'h08);

      // run 3: writes attempted while busy
      push(8'h0F, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      push(N2,    2'd2, 1'b0);
      push(8'h23, 2'd3, 1'b1);
      send(8'h0F);
      @(posedge clk);
      #1;
      chk("cfg_ready_busy", cfg_ready, 0);
      cfgw(2'd0, 4'd0, 8'hAA);
      cfgw(2'd0, 4'd8, 8'hAA);
      wait_last();

      // run 4: bank must be untouched by the busy writes
      push(8'h0F, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      push(N2,    2'd2, 1'b0);
      push(8'h23, 2'd3, 1'b1);
      send(8'h0F);
      @(posedge clk);
      #1;
      wait_last();

      // run 5: reset during neuron2 hold
      res_ready = 1'b0;
      push(8'h29, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      send(8'hFF);
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      wait_valid();
      @(posedge clk);
      #1 res_ready = 1'b1;
      @(posedge clk);
      #1 res_ready = 1'b0;
      wait_valid();
      chk("pre_rst_idx", res_idx, 2);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", res_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_pw0", p_w0, 8'h00);
      chk("abort_bias", p_bias, 8'h00);
      @(posedge clk);
      #1;

      // run 6: cleared bank yields zeros
      res_ready = 1'b1;
      push(8'h00, 2'd0, 1'b0);
      push(8'h00, 2'd1, 1'b0);
      push(8'h00, 2'd2, 1'b0);
      push(8'h00, 2'd3, 1'b1);
      send(8'hFF);
      @(posedge clk);
      #1;
      wait_last();

      repeat (3) @(posedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
